// File: rtl/psram_arbiter_if.sv
// Bundle of both requester ports plus the PSRAM word-controller side of the arbiter.
// The slave modport is the arbiter's view; master is the requesters/controller view.
interface psram_arbiter_if;
  logic        p0_req;
  logic        p0_wr;
  logic [21:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic [31:0] p0_rdata;
  logic        p1_req;
  logic        p1_wr;
  logic [21:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic [31:0] p1_rdata;
  logic        m_rd;
  logic        m_wr;
  logic [21:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_q;
  logic        m_busy;
  logic        owner;
  logic        active;

  modport slave (
    input  p0_req, p0_wr, p0_addr, p0_wdata,
    input  p1_req, p1_wr, p1_addr, p1_wdata,
    input  m_q, m_busy,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output m_rd, m_wr, m_addr, m_wdata, owner, active
  );

  modport master (
    output p0_req, p0_wr, p0_addr, p0_wdata,
    output p1_req, p1_wr, p1_addr, p1_wdata,
    output m_q, m_busy,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  m_rd, m_wr, m_addr, m_wdata, owner, active
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port fixed-priority arbiter in front of the 32-bit PSRAM word controller.
// Define PSRAM_ARB_STARVE_EN to let port 1 win after STARVE_LIMIT port-0 grants.
module psram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset_n,
  psram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_badLimit
    $error("psram_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_t      r_state;
  state_t      w_stateNext;
  logic        w_grant;
  logic        w_grantPort;
  logic        w_done;
  logic        w_selWr;
  logic [21:0] w_selAddr;
  logic [31:0] w_selWdata;
  logic        w_starved;

  logic        r_owner;
  logic        r_active;
  logic        r_rd;
  logic        r_wr;
  logic        r_wrOp;
  logic        r_ack0;
  logic        r_ack1;
  logic [21:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

`ifdef PSRAM_ARB_STARVE_EN
  logic [3:0] r_starveCnt;

  assign w_starved = (r_starveCnt == 4'(STARVE_LIMIT));

  // Counts port-0 wins while port 1 waits; any IDLE cycle without p1_req forgets the history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starveCnt <= 4'd0;
    end else if (r_state == IDLE) begin
      if (!bus.p1_req || (w_grant && w_grantPort)) begin
        r_starveCnt <= 4'd0;
      end else if (w_grant && !w_starved) begin
        r_starveCnt <= r_starveCnt + 4'd1;
      end
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    w_grantPort = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.m_busy && (bus.p0_req || bus.p1_req)) begin
          w_grant     = 1'b1;
          w_grantPort = bus.p1_req && (!bus.p0_req || w_starved);
          w_stateNext = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.m_busy) begin
          w_stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.m_busy) begin
          w_done      = 1'b1;
          w_stateNext = RESP;
        end
      end
      RESP:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  assign w_selWr    = w_grantPort ? bus.p1_wr    : bus.p0_wr;
  assign w_selAddr  = w_grantPort ? bus.p1_addr  : bus.p0_addr;
  assign w_selWdata = w_grantPort ? bus.p1_wdata : bus.p0_wdata;

  // Strobes and acks are single-cycle pulses; address, data and owner hold between transactions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner  <= 1'b0;
      r_active <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_wrOp   <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_addr   <= 22'd0;
      r_wdata  <= 32'd0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_grantPort;
        r_active <= 1'b1;
        r_wrOp   <= w_selWr;
        r_rd     <= !w_selWr;
        r_wr     <= w_selWr;
        r_addr   <= w_selAddr;
        r_wdata  <= w_selWdata;
      end
      if (w_done) begin
        if (r_owner) begin
          r_ack1 <= 1'b1;
        end else begin
          r_ack0 <= 1'b1;
        end
        if (!r_wrOp && r_owner) begin
          r_rdata1 <= bus.m_q;
        end
        if (!r_wrOp && !r_owner) begin
          r_rdata0 <= bus.m_q;
        end
      end
      if (r_state == RESP) begin
        r_active <= 1'b0;
      end
    end
  end

  assign bus.p0_ack   = r_ack0;
  assign bus.p1_ack   = r_ack1;
  assign bus.p0_rdata = r_rdata0;
  assign bus.p1_rdata = r_rdata1;
  assign bus.m_rd     = r_rd;
  assign bus.m_wr     = r_wr;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.owner    = r_owner;
  assign bus.active   = r_active;
endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small PSRAM controller model (busy for CTL_LAT cycles).
// Grant-order expectations follow PSRAM_ARB_STARVE_EN when it is defined.
module tb_psram_arbiter;
  localparam int CTL_LAT = 3;

  logic clk;
  logic reset_n;
  psram_arbiter_if bus ();

  psram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;
  int cycleCnt = 0;

  logic [31:0] mem [logic [21:0]];
  logic        ctlBusy;
  logic        forceBusy;
  int          ctlCnt;
  logic [31:0] ctlQ;

  assign bus.m_busy = ctlBusy | forceBusy;
  assign bus.m_q    = ctlQ;

  always @(posedge clk) cycleCnt++;

  // Controller model: latches the strobe, stays busy CTL_LAT cycles, read data valid when busy drops.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctlBusy <= 1'b0;
      ctlCnt  <= 0;
      ctlQ    <= 32'd0;
    end else if (bus.m_rd || bus.m_wr) begin
      ctlBusy <= 1'b1;
      ctlCnt  <= CTL_LAT;
      if (bus.m_rd) begin
        ctlQ <= mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'd0;
      end else begin
        mem[bus.m_addr] = bus.m_wdata;
      end
    end else if (ctlBusy) begin
      if (ctlCnt == 1) ctlBusy <= 1'b0;
      ctlCnt <= ctlCnt - 1;
    end
  end

  int          strobeCount = 0;
  int          wrCount = 0;
  int          p0Acks = 0;
  int          p1Acks = 0;
  int          fallCycle = 0;
  logic        prevBusy = 1'b0;
  logic [21:0] lastAddr;
  logic [31:0] lastWdata;
  logic        grantLog [$];
  int          strobeCycles [$];

  always @(negedge clk) begin
    if (bus.m_rd || bus.m_wr) begin
      strobeCount++;
      if (bus.m_wr) wrCount++;
      grantLog.push_back(bus.owner);
      strobeCycles.push_back(cycleCnt);
      lastAddr  = bus.m_addr;
      lastWdata = bus.m_wdata;
    end
    if (bus.p0_ack) p0Acks++;
    if (bus.p1_ack) p1Acks++;
    if (prevBusy && !bus.m_busy) fallCycle = cycleCnt;
    prevBusy = bus.m_busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  // Raises one port's request and holds it until that port's ack; returns request and ack cycles.
  task automatic applyStimulus(input string tag, input bit port, input bit wr,
                               input logic [21:0] addr, input logic [31:0] wdata,
                               output int reqCycle, output int ackCycle);
    if (port) begin
      bus.p1_wr = wr; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_req = 1'b1;
    end else begin
      bus.p0_wr = wr; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_req = 1'b1;
    end
    reqCycle = cycleCnt;
    ackCycle = -1;
    for (int i = 0; i < 80; i++) begin
      waitCycle();
      if (port ? bus.p1_ack : bus.p0_ack) begin
        ackCycle = cycleCnt;
        break;
      end
    end
    if (port) bus.p1_req = 1'b0;
    else      bus.p0_req = 1'b0;
    checkOutput({tag, "_timeout"}, 32'(ackCycle < 0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int reqC, ackC, reqC1, ackC1, sc0, wc0, a0, a1, base;
  logic expLog [$];

  initial begin
    reset_n = 1'b0;
    forceBusy = 1'b0;
    bus.p0_req = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    mem[22'h000010] = 32'hDEADBEEF;
    mem[22'h000020] = 32'hA5A50020;
    mem[22'h000021] = 32'h5A5A0021;

    repeat (3) waitCycle();
    checkOutput("rst_p0_ack", 32'(bus.p0_ack), 32'd0);
    checkOutput("rst_p1_ack", 32'(bus.p1_ack), 32'd0);
    checkOutput("rst_m_rd", 32'(bus.m_rd), 32'd0);
    checkOutput("rst_m_wr", 32'(bus.m_wr), 32'd0);
    checkOutput("rst_active", 32'(bus.active), 32'd0);
    checkOutput("rst_owner", 32'(bus.owner), 32'd0);
    checkOutput("rst_p0_rdata", bus.p0_rdata, 32'd0);
    checkOutput("rst_m_addr", 32'(bus.m_addr), 32'd0);
    checkOutput("rst_m_wdata", bus.m_wdata, 32'd0);
    reset_n = 1'b1;
    repeat (2) waitCycle();

    // Port 0 read
    sc0 = strobeCount; a1 = p1Acks; base = strobeCycles.size();
    applyStimulus("p0rd", 1'b0, 1'b0, 22'h000010, 32'd0, reqC, ackC);
    checkOutput("p0rd_strobes", 32'(strobeCount - sc0), 32'd1);
    checkOutput("p0rd_isRead", 32'(wrCount), 32'd0);
    checkOutput("p0rd_addr", 32'(lastAddr), 32'h000010);
    checkOutput("p0rd_strobeCycle", 32'(strobeCycles[base]), 32'(reqC + 1));
    checkOutput("p0rd_rdata", bus.p0_rdata, 32'hDEADBEEF);
    checkOutput("p0rd_ackAtDplus1", 32'(ackC), 32'(fallCycle + 1));
    checkOutput("p0rd_p1ack", 32'(p1Acks - a1), 32'd0);
    waitCycle();
    checkOutput("p0rd_ackWidth", 32'(bus.p0_ack), 32'd0);
    checkOutput("p0rd_activeClear", 32'(bus.active), 32'd0);
    checkOutput("p0rd_addrHold", 32'(bus.m_addr), 32'h000010);

    // Port 1 write to the top word, then read it back
    sc0 = strobeCount; wc0 = wrCount; a0 = p0Acks; a1 = p1Acks;
    applyStimulus("p1wr", 1'b1, 1'b1, 22'h3FFFFF, 32'h12345678, reqC, ackC);
    checkOutput("p1wr_strobes", 32'(strobeCount - sc0), 32'd1);
    checkOutput("p1wr_wrStrobes", 32'(wrCount - wc0), 32'd1);
    checkOutput("p1wr_addr", 32'(lastAddr), 32'h3FFFFF);
    checkOutput("p1wr_wdata", lastWdata, 32'h12345678);
    checkOutput("p1wr_owner", 32'(bus.owner), 32'd1);
    checkOutput("p1wr_rdataHeld", bus.p1_rdata, 32'd0);
    checkOutput("p1wr_p0rdataHeld", bus.p0_rdata, 32'hDEADBEEF);
    checkOutput("p1wr_p0ack", 32'(p0Acks - a0), 32'd0);
    waitCycle();
    checkOutput("p1wr_ackWidth", 32'(p1Acks - a1), 32'd1);
    checkOutput("p1wr_wdataHold", bus.m_wdata, 32'h12345678);
    applyStimulus("p1rd", 1'b1, 1'b0, 22'h3FFFFF, 32'd0, reqC, ackC);
    checkOutput("p1rd_rdata", bus.p1_rdata, 32'h12345678);
    waitCycle();

    // Simultaneous reads: port 0 first, port 1 in the IDLE right after RESP
    grantLog.delete(); strobeCycles.delete();
    fork
      applyStimulus("simP0", 1'b0, 1'b0, 22'h000020, 32'd0, reqC, ackC);
      applyStimulus("simP1", 1'b1, 1'b0, 22'h000021, 32'd0, reqC1, ackC1);
    join
    checkOutput("sim_grants", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() == 2) begin
      checkOutput("sim_first", 32'(grantLog[0]), 32'd0);
      checkOutput("sim_second", 32'(grantLog[1]), 32'd1);
      checkOutput("sim_p1GrantCycle", 32'(strobeCycles[1]), 32'(ackC + 2));
    end
    checkOutput("sim_p0rdata", bus.p0_rdata, 32'hA5A50020);
    checkOutput("sim_p1rdata", bus.p1_rdata, 32'h5A5A0021);
    waitCycle();

    // Continuous port-0 traffic with port 1 waiting
    grantLog.delete();
`ifdef PSRAM_ARB_STARVE_EN
    expLog = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    expLog = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    bus.p0_wr = 1'b0; bus.p0_addr = 22'h000010; bus.p0_req = 1'b1;
    bus.p1_wr = 1'b0; bus.p1_addr = 22'h000021; bus.p1_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      waitCycle();
      if (bus.p1_ack) bus.p1_req = 1'b0;
      if (bus.p0_ack && grantLog.size() >= 6) bus.p0_req = 1'b0;
      if (!bus.p0_req && !bus.p1_req && !bus.active) break;
    end
    checkOutput("starve_done", 32'(bus.p0_req | bus.p1_req), 32'd0);
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    checkOutput("starve_grants", 32'(grantLog.size()), 32'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < grantLog.size(); i++) begin
      checkOutput($sformatf("starve_order%0d", i), 32'(grantLog[i]), 32'(expLog[i]));
    end
    waitCycle();

    // Reset during WAIT_DONE of a port-1 read
    a0 = p0Acks; a1 = p1Acks;
    bus.p1_wr = 1'b0; bus.p1_addr = 22'h000020; bus.p1_req = 1'b1;
    base = 0;
    for (int i = 0; i < 20 && base < 2; i++) begin
      waitCycle();
      if (bus.m_busy) base++;
    end
    checkOutput("rstmid_reachedDone", 32'(base), 32'd2);
    reset_n = 1'b0;
    bus.p1_req = 1'b0;
    #1;
    checkOutput("rstmid_active", 32'(bus.active), 32'd0);
    checkOutput("rstmid_owner", 32'(bus.owner), 32'd0);
    checkOutput("rstmid_m_addr", 32'(bus.m_addr), 32'd0);
    checkOutput("rstmid_p1rdata", bus.p1_rdata, 32'd0);
    checkOutput("rstmid_p0rdata", bus.p0_rdata, 32'd0);
    repeat (2) waitCycle();
    reset_n = 1'b1;
    repeat (4) waitCycle();
    checkOutput("rstmid_noAck", 32'((p0Acks - a0) + (p1Acks - a1)), 32'd0);
    applyStimulus("postRst", 1'b0, 1'b0, 22'h000010, 32'd0, reqC, ackC);
    checkOutput("postRst_rdata", bus.p0_rdata, 32'hDEADBEEF);
    waitCycle();

    // m_busy held high while idle blocks the grant
    sc0 = strobeCount; strobeCycles.delete();
    forceBusy = 1'b1;
    bus.p0_wr = 1'b0; bus.p0_addr = 22'h000020; bus.p0_req = 1'b1;
    repeat (5) waitCycle();
    checkOutput("busyHold_noStrobe", 32'(strobeCount - sc0), 32'd0);
    checkOutput("busyHold_active", 32'(bus.active), 32'd0);
    forceBusy = 1'b0;
    base = cycleCnt;
    applyStimulus("busyHold", 1'b0, 1'b0, 22'h000020, 32'd0, reqC, ackC);
    checkOutput("busyHold_strobes", 32'(strobeCount - sc0), 32'd1);
    if (strobeCycles.size() > 0) begin
      checkOutput("busyHold_strobeCycle", 32'(strobeCycles[0]), 32'(base + 1));
    end
    checkOutput("busyHold_rdata", bus.p0_rdata, 32'hA5A50020);

    repeat (2) waitCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule

// File: doc/psram_arbiter.md
# psram_arbiter

Two-port arbiter that shares the single 32-bit PSRAM word interface between the CPU data bus (port 0) and a DMA/fetch master (port 1). It sits between the requesters and the 32-bit PSRAM word controller. It sequences each granted request as one strobe/busy transaction on the controller and returns an ack with read data to the owning port. Port 0 has fixed priority. A compile-time starvation guard bounds how long port 1 can wait.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive port-0 grants tolerated while port 1 waits (1..15). Used only with the starvation guard.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 request; held until p0_ack
- p0_wr  in  1  1 = write, 0 = read; stable while p0_req
- p0_addr  in  22  word address; stable while p0_req
- p0_wdata  in  32  write data; stable while p0_req
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  32  read data; valid in the p0_ack cycle
- p1_req, p1_wr, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- m_rd  out  1  one-cycle read strobe to the controller
- m_wr  out  1  one-cycle write strobe to the controller
- m_addr  out  22  word address to the controller
- m_wdata  out  32  write data to the controller
- m_q  in  32  controller read data; valid once m_busy falls
- m_busy  in  1  controller busy
- owner  out  1  port of the current or last grant
- active  out  1  high from grant until ack

## Operation
- Registered FSM with states IDLE, WAIT_BUSY, WAIT_DONE and RESP.
- IDLE: grants only when m_busy = 0 and at least one req is high.
  - Default winner is port 0.
  - With the guard, port 1 wins if p1_req is high and starve_cnt == STARVE_LIMIT.
  - On grant: latch wr/addr/wdata into m_addr/m_wdata, pulse m_rd or m_wr for one cycle, set owner, set active, go to WAIT_BUSY.
- WAIT_BUSY: wait for m_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for m_busy = 0.
  - On a read, register m_q into the owner's rdata. The other port's rdata holds its value.
  - Pulse the owner's ack for one cycle and go to RESP.
- RESP: ack is high this cycle. Clear active and return to IDLE.
- req seen high in IDLE after an ack is a new request. Requesters must deassert req, or present a new request, in the cycle after ack.
- m_addr and m_wdata hold their values between transactions.
- The non-owner's ack is never asserted.
- Reset values: all acks 0, m_rd 0, m_wr 0, active 0, owner 0, rdata 0, m_addr 0, m_wdata 0, starve_cnt 0, state IDLE.
- Reset asserted mid-transaction: return to IDLE immediately and drop the in-flight transaction without any ack. The controller shares reset_n.

## Timing
- The req sampling edge in IDLE is cycle T.
- m_rd or m_wr is high during cycle T+1 only.
- m_busy rises at T+2. WAIT_BUSY holds until m_busy is seen high.
- m_busy falls at cycle D. ack and rdata are valid at D+1.
- Arbiter overhead is 2 cycles per transaction on top of the controller latency.
- Back-to-back requests: the next grant comes at the earliest in the IDLE cycle after RESP. Minimum spacing between ack pulses is controller time + 3 cycles.
- Simultaneous req with no guard trip: port 0 wins, and port 1 is granted in the next IDLE if p0_req is low there.

## Configuration
- PSRAM_ARB_STARVE_EN defined:
  - starve_cnt (4 bits) increments on each port-0 grant made while p1_req is high, saturating at STARVE_LIMIT.
  - It clears on a port-1 grant, or in IDLE when p1_req is low.
  - When starve_cnt == STARVE_LIMIT, port 1 wins the next arbitration.
- PSRAM_ARB_STARVE_EN undefined: strict fixed priority and no counter. Port 1 is granted only in an IDLE cycle with p0_req low.

## Test plan
- Port 0 read, p0_addr 0x000010, controller model returns 0xDEADBEEF → exactly one m_rd pulse with m_addr 0x000010; p0_ack one cycle with p0_rdata 0xDEADBEEF at D+1; p1_ack stays 0.
- Port 1 write 0x12345678 to 0x3FFFFF → one m_wr pulse with m_wdata 0x12345678 and m_addr 0x3FFFFF; p1_ack one cycle; p1_rdata unchanged.
- p0_req and p1_req rise in the same cycle, both reads → port 0 is served first; port 1 is granted in the IDLE after RESP; owner reads 0, then 1.
- Continuous p0_req with p1_req held, STARVE_LIMIT = 4 → macro on: grant order 0,0,0,0,1 repeating. Macro off: port 1 is never granted until p0_req drops.
- reset_n pulsed low during WAIT_DONE → all outputs return to reset values asynchronously; no ack; the next request after release completes normally.
- m_busy held high at idle with p0_req high → no strobe until m_busy = 0; then a strobe in the following cycle.
